// File: rtl/riscv_pkg.sv
// Shared load/store size encodings (RISC-V funct3) and LSU state type.
package riscv_pkg;

   localparam logic [2:0] LDST_B  = 3'd0;
   localparam logic [2:0] LDST_H  = 3'd1;
   localparam logic [2:0] LDST_W  = 3'd2;
   localparam logic [2:0] LDST_BU = 3'd4;
   localparam logic [2:0] LDST_HU = 3'd5;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DONE
   } lsu_state_t;

endpackage

// File: rtl/riscv_lsu_if.sv
// Core-side and memory-side signals of the load/store unit.
interface riscv_lsu_if;

   logic        core_req_i;
   logic        core_we_i;
   logic [2:0]  core_size_i;
   logic [31:0] core_addr_i;
   logic [31:0] core_wd_i;
   logic [31:0] core_rd_o;
   logic        core_stall_o;
   logic        core_misalign_o;
   logic        mem_req_o;
   logic        mem_we_o;
   logic [3:0]  mem_be_o;
   logic [31:0] mem_addr_o;
   logic [31:0] mem_wd_o;
   logic [31:0] mem_rd_i;
   logic        mem_ready_i;

   // LSU view
   modport slave (
      input  core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
      input  mem_rd_i, mem_ready_i,
      output core_rd_o, core_stall_o, core_misalign_o,
      output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o
   );

   // Environment view: core plus data memory
   modport master (
      output core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
      output mem_rd_i, mem_ready_i,
      input  core_rd_o, core_stall_o, core_misalign_o,
      input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o
   );

endinterface

// File: rtl/riscv_lsu_extract.sv
// Selects the addressed byte/half of a memory word and sign- or zero-extends it.
module riscv_lsu_extract
   import riscv_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  offset,
   input  logic [2:0]  size,
   output logic [31:0] data
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;

   always_comb begin
      byte_v = word[8*offset +: 8];
      half_v = offset[1] ? word[31:16] : word[15:0];
      data   = word;
      case (size)
         LDST_B:  data = {{24{byte_v[7]}}, byte_v};
         LDST_BU: data = {24'd0, byte_v};
         LDST_H:  data = {{16{half_v[15]}}, half_v};
         LDST_HU: data = {16'd0, half_v};
         default: data = word;
      endcase
   end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: word-aligned memory handshake with byte enables and load extension.
module riscv_lsu
   import riscv_pkg::*;
(
   input  logic      clk_i,
   input  logic      rst_i,
   riscv_lsu_if.slave bus
);

   lsu_state_t  state_q, state_d;
   logic [31:0] rd_q;
   logic [31:0] rd_ext;
   logic        size_h, size_w, size_bad, bad, accepted, mem_req;
   logic [1:0]  offset;

   assign offset = bus.core_addr_i[1:0];

   riscv_lsu_extract u_extract (
      .word   (rd_q),
      .offset (offset),
      .size   (bus.core_size_i),
      .data   (rd_ext)
   );

   always_comb begin
      size_h   = (bus.core_size_i == LDST_H) || (bus.core_size_i == LDST_HU);
      size_w   = (bus.core_size_i == LDST_W);
      size_bad = (bus.core_size_i == 3'd3) || (bus.core_size_i == 3'd6) ||
                 (bus.core_size_i == 3'd7);
      bad      = bus.core_req_i && (size_bad || (size_h && offset[0]) ||
                                    (size_w && (offset != 2'b00)));
      accepted = bus.core_req_i && !bad;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         rd_q    <= '0;
      end else begin
         state_q <= state_d;
         if (mem_req && bus.mem_ready_i)
            rd_q <= bus.mem_rd_i;
      end
   end

   always_comb begin
      state_d = state_q;
      mem_req = 1'b0;
      case (state_q)
         IDLE: begin
            if (accepted) begin
               mem_req = 1'b1;
               state_d = bus.mem_ready_i ? DONE : WAIT;
            end
         end
         WAIT: begin
            mem_req = 1'b1;
            if (bus.mem_ready_i)
               state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.core_misalign_o = bad;
      bus.core_stall_o    = accepted && (state_q != DONE);
      bus.mem_req_o       = mem_req;
      bus.mem_we_o        = bus.core_we_i && mem_req;
      bus.mem_addr_o      = '0;
      bus.mem_be_o        = '0;
      bus.mem_wd_o        = '0;
      if (mem_req) begin
         bus.mem_addr_o = {bus.core_addr_i[31:2], 2'b00};
         if (size_w) begin
            bus.mem_be_o = 4'b1111;
            bus.mem_wd_o = bus.core_wd_i;
         end else if (size_h) begin
            bus.mem_be_o = 4'b0011 << {offset[1], 1'b0};
            bus.mem_wd_o = {2{bus.core_wd_i[15:0]}};
         end else begin
            bus.mem_be_o = 4'b0001 << offset;
            bus.mem_wd_o = {4{bus.core_wd_i[7:0]}};
         end
      end
      bus.core_rd_o = (state_q == DONE && !bus.core_we_i) ? rd_ext : '0;
   end

endmodule
